bist_datapath: RTL
==================

# bist_datapath

Address-generation and response-check datapath driven by the BIST controller `mem_FSM`. It consumes the controller's counter controls (`reset`, `preset`, `en`, `up_down`) and access controls (`read`, `write`, `data`). It contains the embedded memory under test, and returns `carry` (terminal address reached) and `is_equal` (last read matched the expected background). It also keeps a first-fail address log and a saturating mismatch counter for diagnosis, plus a stuck-at fault-injection hook for verification.

## Interface
- `ADDR_W`, 4: address width; memory depth is 2^ADDR_W words.
- `DATA_W`, 8: memory word width; background bit `data` is replicated across the word.
- `FCNT_W`, 4: width of the saturating mismatch counter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `reset`  in  1: synchronous address clear to 0 (from controller).
- `preset`  in  1: synchronous address load to all-ones.
- `en`  in  1: address step enable.
- `up_down`  in  1: 1 = count up, 0 = count down.
- `read`  in  1: read memory at current address.
- `write`  in  1: write `{DATA_W{data}}` at current address.
- `data`  in  1: background bit for write and for expected read value.
- `inj_en`  in  1: stuck-at injection enable.
- `inj_addr`  in  ADDR_W: injected address.
- `inj_bit`  in  $clog2(DATA_W): injected bit index.
- `inj_val`  in  1: stuck-at value.
- `carry`  out  1: terminal count this cycle.
- `is_equal`  out  1: last read data equals its expected word.
- `addr`  out  ADDR_W: current address.
- `fail_valid`  out  1: at least one mismatch logged.
- `fail_addr`  out  ADDR_W: address of first mismatch.
- `fail_cnt`  out  FCNT_W: mismatch count, saturating.

## Operation
- **Address register priority:** `reset` > `preset` > `en`.
  - `en` with `up_down=1`: addr+1. With `up_down=0`: addr−1.
  - Modulo 2^ADDR_W wrap (max→0 up, 0→max down).
- **carry (combinational):** `en & ((up_down & addr==max) | (~up_down & addr==0))`. It is forced 0 when `reset` or `preset` is asserted.
- **Write:** when `write`=1, `mem[addr] <= {DATA_W{data}}` at the clock edge.
- **Read:** when `read`=1, the `rdata` register captures `mem[addr]` (pre-write value if `write` is also 1: read-before-write). Stuck-at override applies when `inj_en` and `inj_addr==addr`: bit `inj_bit` forced to `inj_val`.
  - `exp` register captures `{DATA_W{data}}` and `chk_addr` captures `addr` in the same edge.
  - A one-cycle `chk` flag is set.
- **is_equal:** `rdata==exp`, held until the next read.
- **Fail logging:** in the `chk` cycle with a mismatch:
  - `fail_cnt` increments and saturates at all-ones.
  - If `fail_valid`=0, `fail_addr <= chk_addr` and `fail_valid <= 1`.
  - The log is cleared only by `rst` or by `reset` together with `preset` in the same cycle (log-clear command).
- **Memory contents:** not reset; reads of unwritten words return X. Benches always write before read.

## Timing
- **Reset values:** `addr=0`, `rdata=0`, `exp=0` (so `is_equal=1`), `chk=0`, `fail_valid=0`, `fail_addr=0`, `fail_cnt=0`, `carry=0`.
- **Address:** update latency 1 cycle. `carry` is valid in the same cycle as the final `en` so the controller can exit the march element without an extra access.
- **Read to compare:** `read` at edge N gives `is_equal` valid after edge N and `fail_*` updated at edge N+1.
- **Back-to-back reads:** each compare is evaluated independently; no bubbles required.
- **rst mid-march:** all registers return to reset values immediately; memory is retained.
- **Simultaneous events:** simultaneous `read`, `write`, and `en` are legal. Access uses the pre-increment address.

## Structure
- Package `bist_pkg`: default `ADDR_W`/`DATA_W`/`FCNT_W`, `UP=1'b1`/`DOWN=1'b0` constants.
- Sub-module `bist_addr_counter`: address register, priority logic, `carry`.
- Memory array, compare, and fail log are inline in `bist_datapath`.

## Test plan
- **Up sweep:** `rst`, then `reset`, then `en=1 up_down=1` for 16 cycles. Expect `addr` 0..15 then 0; `carry` high only while `addr=15`.
- **Down sweep:** `preset`, then `en=1 up_down=0`. Expect `addr` 15..0; `carry` high only at `addr=0`; `preset`+`en` same cycle yields 15.
- **Write/read all addresses:**
  - Write `data=0` to all 16 addresses, then read ascending with `data=0`. Expect `is_equal=1` throughout and `fail_cnt=0`.
  - Repeat with `data=1`: each word reads 8'hFF.
- **Fault injection:** `inj_en=1 inj_addr=5 inj_bit=3 inj_val=0`, write 1s, read all. Expect `is_equal=0` only for the addr-5 read, `fail_valid=1`, `fail_addr=5`, `fail_cnt=1`.
- **Saturation and log clear:** inject on every address over 2 passes. Expect `fail_cnt` to saturate at 15 and `fail_addr` to stay at the first failing address. `reset`+`preset` together clears the log.
- **Mid-operation rst and read-before-write:**
  - Assert `rst` during a sweep at `addr=7`. Expect `addr=0` and `is_equal=1` immediately; memory retained on a subsequent read.
  - Read+write same cycle: `rdata` equals the old word.

Source files
------------

// File: rtl/bist_pkg.sv
// bist_pkg: shared defaults and constants for the BIST address/compare datapath.
//   BIST_ADDR_W : default address width (memory depth = 2**BIST_ADDR_W)
//   BIST_DATA_W : default memory word width
//   BIST_FCNT_W : default width of the saturating mismatch counter
//   UP / DOWN   : encodings of the controller's up_down input
package bist_pkg;

    localparam int BIST_ADDR_W = 4;
    localparam int BIST_DATA_W = 8;
    localparam int BIST_FCNT_W = 4;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

endpackage : bist_pkg

// File: rtl/bist_addr_counter.sv
// bist_addr_counter: up/down address register driven by the BIST controller.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   reset           : synchronous clear to 0 (highest priority)
//   preset          : synchronous load to all-ones
//   en, up_down     : step enable and direction (UP = increment)
//   addr            : current address
//   carry           : combinational terminal-count flag for the current step
module bist_addr_counter
    import bist_pkg::*;
#(
    parameter int ADDR_W = BIST_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reset,
    input  logic              preset,
    input  logic              en,
    input  logic              up_down,
    output logic [ADDR_W-1:0] addr,
    output logic              carry
);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_next_s;
    logic              carry_s;

    // Next-address selection: reset > preset > en; modulo wrap is natural overflow.
    always_comb begin
        addr_next_s = addr_r;
        if (reset) begin
            addr_next_s = ADDR_ZERO;
        end else if (preset) begin
            addr_next_s = ADDR_MAX;
        end else if (en) begin
            if (up_down == UP) begin
                addr_next_s = addr_r + ADDR_ONE;
            end else begin
                addr_next_s = addr_r - ADDR_ONE;
            end
        end else begin
            addr_next_s = addr_r;
        end
    end

    // Address register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r <= ADDR_ZERO;
        end else begin
            addr_r <= addr_next_s;
        end
    end

    // Terminal count is flagged in the same cycle as the last step so the
    // controller can leave the march element without an extra access.
    // A pending reset/preset overrides the step, so carry is suppressed then.
    always_comb begin
        carry_s = 1'b0;
        if (reset || preset) begin
            carry_s = 1'b0;
        end else if (en) begin
            if (up_down == UP) begin
                carry_s = (addr_r == ADDR_MAX);
            end else begin
                carry_s = (addr_r == ADDR_ZERO);
            end
        end else begin
            carry_s = 1'b0;
        end
    end

    assign addr  = addr_r;
    assign carry = carry_s;

endmodule : bist_addr_counter

// File: rtl/bist_datapath.sv
// bist_datapath: address generation, embedded memory under test, read compare
// and first-fail diagnosis log for a march-style memory BIST.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   reset, preset, en, up_down    : address counter controls
//   read, write, data             : access controls; data is the background bit
//   inj_en, inj_addr, inj_bit,
//   inj_val                       : stuck-at fault injection on the read path
//   carry                         : terminal address reached this cycle
//   is_equal                      : last read matched its expected word
//   addr                          : current address
//   fail_valid, fail_addr         : first-mismatch log
//   fail_cnt                      : saturating mismatch count
module bist_datapath
    import bist_pkg::*;
#(
    parameter int ADDR_W = BIST_ADDR_W,
    parameter int DATA_W = BIST_DATA_W,
    parameter int FCNT_W = BIST_FCNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      reset,
    input  logic                      preset,
    input  logic                      en,
    input  logic                      up_down,
    input  logic                      read,
    input  logic                      write,
    input  logic                      data,
    input  logic                      inj_en,
    input  logic [ADDR_W-1:0]         inj_addr,
    input  logic [$clog2(DATA_W)-1:0] inj_bit,
    input  logic                      inj_val,
    output logic                      carry,
    output logic                      is_equal,
    output logic [ADDR_W-1:0]         addr,
    output logic                      fail_valid,
    output logic [ADDR_W-1:0]         fail_addr,
    output logic [FCNT_W-1:0]         fail_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [FCNT_W-1:0] FCNT_ZERO = {FCNT_W{1'b0}};
    localparam logic [FCNT_W-1:0] FCNT_MAX  = {FCNT_W{1'b1}};
    localparam logic [FCNT_W-1:0] FCNT_ONE  = {{(FCNT_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic [ADDR_W-1:0] addr_s;
    logic              carry_s;
    logic [DATA_W-1:0] bg_word_s;
    logic [DATA_W-1:0] rd_word_s;
    logic              match_s;
    logic              log_clear_s;

    logic [DATA_W-1:0] rdata_r;
    logic [DATA_W-1:0] exp_r;
    logic [ADDR_W-1:0] chk_addr_r;
    logic              chk_r;
    logic              fail_valid_r;
    logic [ADDR_W-1:0] fail_addr_r;
    logic [FCNT_W-1:0] fail_cnt_r;

    bist_addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_addr_counter (
        .clk     (clk),
        .rst     (rst),
        .reset   (reset),
        .preset  (preset),
        .en      (en),
        .up_down (up_down),
        .addr    (addr_s),
        .carry   (carry_s)
    );

    assign bg_word_s   = {DATA_W{data}};
    assign log_clear_s = reset & preset;

    // Read path with stuck-at override; accesses always use the pre-step address.
    always_comb begin
        rd_word_s = mem_r[addr_s];
        if (inj_en && (inj_addr == addr_s)) begin
            rd_word_s[inj_bit] = inj_val;
        end else begin
            rd_word_s = mem_r[addr_s];
        end
    end

    // Memory array: deliberately not reset so contents survive rst mid-march.
    always_ff @(posedge clk) begin
        if (write) begin
            mem_r[addr_s] <= bg_word_s;
        end
    end

    // Read capture: rdata takes the pre-write word, exp/chk_addr the context.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r    <= DATA_ZERO;
            exp_r      <= DATA_ZERO;
            chk_addr_r <= ADDR_ZERO;
            chk_r      <= 1'b0;
        end else begin
            chk_r <= read;
            if (read) begin
                rdata_r    <= rd_word_s;
                exp_r      <= bg_word_s;
                chk_addr_r <= addr_s;
            end
        end
    end

    assign match_s = (rdata_r == exp_r);

    // Fail log: saturating count and sticky first-fail address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_valid_r <= 1'b0;
            fail_addr_r  <= ADDR_ZERO;
            fail_cnt_r   <= FCNT_ZERO;
        end else if (log_clear_s) begin
            fail_valid_r <= 1'b0;
            fail_addr_r  <= ADDR_ZERO;
            fail_cnt_r   <= FCNT_ZERO;
        end else if (chk_r && !match_s) begin
            if (fail_cnt_r != FCNT_MAX) begin
                fail_cnt_r <= fail_cnt_r + FCNT_ONE;
            end
            if (!fail_valid_r) begin
                fail_valid_r <= 1'b1;
                fail_addr_r  <= chk_addr_r;
            end
        end
    end

    assign carry      = carry_s;
    assign addr       = addr_s;
    assign is_equal   = match_s;
    assign fail_valid = fail_valid_r;
    assign fail_addr  = fail_addr_r;
    assign fail_cnt   = fail_cnt_r;

endmodule : bist_datapath
